// File: rtl/morse_symbol_timer.sv
// morse_symbol_timer: times keyed marks and silences in Morse units and emits
// one-cycle DIT/DAH/GAP/SPACE codes for the downstream decoder FSM.
module morse_symbol_timer #(
    parameter int UNIT_CYCLES = 4,
    parameter int DAH_UNITS   = 2,
    parameter int GAP_UNITS   = 3,
    parameter int SPACE_UNITS = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       key_in,
    output logic [2:0] symbol,
    output logic       symbol_valid,
    output logic       mark_overflow
);
    localparam int PW = $clog2(UNIT_CYCLES);
    localparam logic [2:0] WAIT = 3'd0, DIT = 3'd1, DAH = 3'd2, GAP = 3'd3, SPACE = 3'd4;

    typedef enum logic [1:0] {IDLE, MARK, INTRA, LGAP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic [3:0]    elapsed_q, elapsed_d, elapsed_inc;
    logic [2:0]    symbol_q, symbol_d;
    logic          valid_q, ovf_q, ovf_d;
    logic          sync1_q, key_s_q, key_d_q;
    logic          rise, fall, wrap;

    assign rise = key_s_q & ~key_d_q;
    assign fall = ~key_s_q & key_d_q;
    assign wrap = prescale_q == PW'(UNIT_CYCLES - 1);
    // Classification uses the count including this cycle's wrap, so a mark of
    // P clocks measures floor(P/UNIT_CYCLES).
    assign elapsed_inc = (wrap && elapsed_q != 4'hf) ? elapsed_q + 4'd1 : elapsed_q;

    always_comb begin
        state_d    = state_q;
        symbol_d   = WAIT;
        ovf_d      = ovf_q;
        prescale_d = wrap ? '0 : prescale_q + 1'b1;
        elapsed_d  = elapsed_inc;
        if (!enable) begin
            state_d    = IDLE;
            prescale_d = '0;
            elapsed_d  = '0;
        end else begin
            if (state_q == MARK && elapsed_inc == 4'hf) ovf_d = 1'b1;
            if (rise || fall) begin
                prescale_d = '0;
                elapsed_d  = '0;
            end
            if (rise) begin
                state_d = MARK;
            end else if (fall) begin
                if (state_q == MARK) begin
                    symbol_d = (elapsed_inc >= 4'(DAH_UNITS)) ? DAH : DIT;
                    state_d  = INTRA;
                end
            end else if (wrap && state_q == INTRA && elapsed_inc == 4'(GAP_UNITS)) begin
                symbol_d = GAP;
                state_d  = LGAP;
            end else if (wrap && state_q == LGAP && elapsed_inc == 4'(SPACE_UNITS)) begin
                symbol_d = SPACE;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prescale_q <= '0;
            elapsed_q  <= '0;
            symbol_q   <= WAIT;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            sync1_q    <= 1'b0;
            key_s_q    <= 1'b0;
            key_d_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            elapsed_q  <= elapsed_d;
            symbol_q   <= symbol_d;
            valid_q    <= symbol_d != WAIT;
            ovf_q      <= ovf_d;
            sync1_q    <= key_in;
            key_s_q    <= sync1_q;
            key_d_q    <= key_s_q;
        end
    end

    assign symbol        = symbol_q;
    assign symbol_valid  = valid_q;
    assign mark_overflow = ovf_q;
endmodule

// File: tb/tb_morse_symbol_timer.sv
// tb_morse_symbol_timer: table rows, hand corner sequences and random keying,
// all checked every cycle against a cycle-count reference model.
module tb_morse_symbol_timer;
    localparam int U = 4, DAH_U = 2, GAP_U = 3, SPACE_U = 7;

    logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, key_in = 1'b0;
    logic [2:0] symbol;
    logic       symbol_valid, mark_overflow;
    int         checks = 0, errors = 0;
    logic [2:0] got[$];

    morse_symbol_timer #(.UNIT_CYCLES(U), .DAH_UNITS(DAH_U), .GAP_UNITS(GAP_U), .SPACE_UNITS(SPACE_U)) dut (
        .clk(clk), .reset(reset), .enable(enable), .key_in(key_in),
        .symbol(symbol), .symbol_valid(symbol_valid), .mark_overflow(mark_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: d1..d3 model the key delay line, n counts clocks since the
    // last key edge; symbols follow from whole-unit arithmetic on that count.
    bit         d1, d2, d3, m_ovf, m_rise, m_fall;
    int         mode, n, t;
    logic [2:0] m_sym = 3'd0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            d1 = 0; d2 = 0; d3 = 0; mode = 0; n = 0; m_sym = 0; m_ovf = 0;
        end else begin
            m_rise = d2 & ~d3;
            m_fall = ~d2 & d3;
            d3 = d2; d2 = d1; d1 = key_in;
            m_sym = 0;
            t = n + 1;
            if (!enable) begin
                mode = 0; n = 0;
            end else begin
                if (mode == 1 && t >= 15 * U) m_ovf = 1;
                n = (m_rise || m_fall) ? 0 : t;
                if (m_rise) mode = 1;
                else if (m_fall && mode == 1) begin m_sym = (t / U >= DAH_U) ? 3'd2 : 3'd1; mode = 2; end
                else if (!m_fall && mode == 2 && t == GAP_U * U) begin m_sym = 3'd3; mode = 3; end
                else if (!m_fall && mode == 3 && t == SPACE_U * U) begin m_sym = 3'd4; mode = 0; end
            end
        end
    end

    always @(negedge clk) if (!reset) begin
        chk("symbol", 32'(symbol), 32'(m_sym));
        chk("symbol_valid", 32'(symbol_valid), 32'(m_sym != 0));
        chk("mark_overflow", 32'(mark_overflow), 32'(m_ovf));
        if (symbol != 0) got.push_back(symbol);
    end

    task automatic tick(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; key_in = 0;
        tick(2);
        reset = 0; enable = 1;
        got.delete();
        tick(2);
    endtask

    task automatic pulse(int mark, int sil);
        key_in = 1; tick(mark);
        key_in = 0; tick(sil);
    endtask

    task automatic check_seq(string nm, int cnt, logic [11:0] seq);
        chk({nm, "_count"}, 32'(got.size()), 32'(cnt));
        for (int j = 0; j < cnt && j < got.size(); j++)
            chk($sformatf("%s_sym%0d", nm, j), 32'(got[j]), 32'(seq[11 - 3 * j -: 3]));
    endtask

    typedef struct {
        int         mark;
        int         sil;
        int         cnt;
        logic [11:0] seq;
        logic       ovf;
    } vec_t;
    vec_t tbl[10];
    int   r;

    initial begin
        tbl[0] = '{4, 40, 3, 12'o1340, 1'b0};
        tbl[1] = '{7, 4, 1, 12'o1000, 1'b0};
        tbl[2] = '{8, 4, 1, 12'o2000, 1'b0};
        tbl[3] = '{3, 14, 2, 12'o1300, 1'b0};
        tbl[4] = '{20, 8, 1, 12'o2000, 1'b0};
        tbl[5] = '{1, 4, 1, 12'o1000, 1'b0};
        tbl[6] = '{70, 40, 3, 12'o2340, 1'b1};
        tbl[7] = '{59, 4, 1, 12'o2000, 1'b0};
        tbl[8] = '{60, 4, 1, 12'o2000, 1'b1};
        tbl[9] = '{12, 17, 2, 12'o2300, 1'b0};

        tick(2);
        chk("reset_symbol", 32'(symbol), 0);
        chk("reset_valid", 32'(symbol_valid), 0);
        chk("reset_ovf", 32'(mark_overflow), 0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            pulse(tbl[i].mark, tbl[i].sil);
            tick(4); #1;
            check_seq($sformatf("row%0d", i), tbl[i].cnt, tbl[i].seq);
            chk($sformatf("row%0d_ovf", i), 32'(mark_overflow), 32'(tbl[i].ovf));
        end

        do_reset();
        pulse(4, 4); pulse(12, 30); tick(4); #1;
        check_seq("letter_a", 4, 12'o1234);

        do_reset();
        pulse(4, 12); pulse(8, 4); tick(4); #1;
        check_seq("rise_at_gap", 2, 12'o1200);
        do_reset();
        pulse(4, 11); pulse(8, 4); tick(4); #1;
        check_seq("rise_before_gap", 2, 12'o1200);
        do_reset();
        pulse(4, 13); pulse(8, 4); tick(4); #1;
        check_seq("rise_after_gap", 3, 12'o1320);

        do_reset();
        key_in = 1; tick(10);
        reset = 1; #1;
        chk("rst_mark_symbol", 32'(symbol), 0);
        chk("rst_mark_valid", 32'(symbol_valid), 0);
        key_in = 0; tick(2); reset = 0; got.delete();
        tick(30); #1;
        check_seq("after_rst_mark", 0, 12'o0);

        do_reset();
        pulse(4, 20);
        reset = 1; #1;
        chk("rst_lgap_symbol", 32'(symbol), 0);
        tick(2); reset = 0; got.delete();
        tick(40); #1;
        check_seq("after_rst_lgap", 0, 12'o0);

        do_reset();
        key_in = 1; tick(6);
        enable = 0; got.delete();
        for (int i = 0; i < 20; i++) begin key_in = 1'($urandom_range(0, 1)); tick(1); end
        key_in = 1; tick(4);
        enable = 1; tick(10);
        key_in = 0; tick(30); #1;
        check_seq("disabled", 0, 12'o0);

        do_reset();
        pulse(70, 10); #1;
        chk("ovf_set", 32'(mark_overflow), 1);
        enable = 0; tick(5); #1;
        chk("ovf_hold_disabled", 32'(mark_overflow), 1);
        enable = 1; pulse(4, 20); #1;
        chk("ovf_hold_dit", 32'(mark_overflow), 1);
        reset = 1; #1;
        chk("ovf_cleared", 32'(mark_overflow), 0);
        tick(1);

        do_reset();
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin reset = 1; tick(1); reset = 0; end
            else if (r == 1) begin enable = 0; tick(int'($urandom_range(1, 10))); enable = 1; end
            pulse(int'($urandom_range(1, 70)), int'($urandom_range(1, 40)));
        end
        tick(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
